// File: rtl/dvi_pkg.sv
// Shared DVI definitions: TMDS symbol width, the four control-period
// symbols and a popcount helper used by the TMDS channel encoder.
package dvi_pkg;

  localparam int TMDS_SYM_W = 10;

  // Control symbols, indexed by {c1,c0}; bit 0 is transmitted first.
  localparam logic [TMDS_SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_SYM_W-1:0] CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    CODE_00 = 2'b00,
    CODE_01 = 2'b01,
    CODE_10 = 2'b10,
    CODE_11 = 2'b11
  } ctrl_code_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [TMDS_SYM_W-1:0] ctrl_symbol(input logic [1:0] c);
    logic [TMDS_SYM_W-1:0] s;
    case (ctrl_code_e'(c))
      CODE_00: s = CTRL_00;
      CODE_01: s = CTRL_01;
      CODE_10: s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel-side bus of one TMDS lane: colour component and blanking controls in,
// 10-bit TMDS symbol out.
interface tmds_encoder_if;
  import dvi_pkg::*;

  // No handshake: the encoder accepts one pixel on every pix_clk edge and
  // never stalls; tmds carries a valid symbol on every cycle, including reset.
  logic                  data_en;
  logic [1:0]            ctrl;
  logic [7:0]            data;
  logic [TMDS_SYM_W-1:0] tmds;

  modport master (output data_en, output ctrl, output data, input tmds);
  modport slave  (input data_en, input ctrl, input data, output tmds);

endinterface

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS channel encoder, one instance per colour lane.
// Stage 1 registers the pixel and forms the transition-minimised word q_m;
// stage 2 applies DC balancing against the running disparity cnt.
// Optional macro TMDS_ENCODER_OUTREG_EN adds an output register (latency 3
// instead of 2).
module tmds_encoder
  import dvi_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic           pix_clk,
  input  logic           resetn,
  tmds_encoder_if.slave  bus
);

  // CHANNEL only labels the lane; reject nonsense values at elaboration.
  if (CHANNEL < 0 || CHANNEL > 2) begin : g_bad_channel
    $error("tmds_encoder: CHANNEL must be in 0..2");
  end

  logic                  s1_en;
  logic [1:0]            s1_ctrl;
  logic [7:0]            s1_data;
  logic [3:0]            n1d;
  logic                  use_xnor;
  logic [8:0]            q_m;
  logic [3:0]            n1;
  logic signed [4:0]     diff;
  logic signed [4:0]     delta;
  logic signed [4:0]     cnt;
  logic signed [4:0]     cnt_nxt;
  logic [TMDS_SYM_W-1:0] sym_nxt;
  logic [TMDS_SYM_W-1:0] s2_sym;

  // Stage 1: capture the pixel and blanking controls.
  always_ff @(posedge pix_clk or negedge resetn) begin
    if (!resetn) begin
      s1_en   <= 1'b0;
      s1_ctrl <= 2'b00;
      s1_data <= 8'h00;
    end else begin
      s1_en   <= bus.data_en;
      s1_ctrl <= bus.ctrl;
      s1_data <= bus.data;
    end
  end

  // Transition minimisation: XNOR chain when the byte is ones-heavy
  // (ties broken on data[0]), XOR chain otherwise; q_m[8] records which.
  always_comb begin
    logic prev;
    logic bit_q;
    n1d      = popcount8(s1_data);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !s1_data[0]);
    q_m      = '0;
    q_m[0]   = s1_data[0];
    prev     = s1_data[0];
    for (int i = 1; i < 8; i++) begin
      bit_q  = use_xnor ? ~(prev ^ s1_data[i]) : (prev ^ s1_data[i]);
      q_m[i] = bit_q;
      prev   = bit_q;
    end
    q_m[8] = ~use_xnor;
  end

  // DC balance: pick inversion from the sign of cnt versus the word's own
  // imbalance. All sums stay within -10..+10, so 5-bit two's complement
  // arithmetic is exact.
  always_comb begin
    n1      = popcount8(q_m[7:0]);
    diff    = $signed({n1, 1'b0}) - 5'sd8;   // n1 - n0
    sym_nxt = CTRL_00;
    delta   = '0;
    if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
      sym_nxt = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      delta   = q_m[8] ? diff : -diff;
    end else if (((cnt > 5'sd0) && (n1 > 4'd4)) ||
                 ((cnt < 5'sd0) && (n1 < 4'd4))) begin
      sym_nxt = {1'b1, q_m[8], ~q_m[7:0]};
      delta   = (q_m[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym_nxt = {1'b0, q_m[8], q_m[7:0]};
      delta   = diff - (q_m[8] ? 5'sd0 : 5'sd2);
    end
    cnt_nxt = cnt + delta;
    // Blanking: emit the control symbol and restart disparity tracking.
    if (!s1_en) begin
      sym_nxt = ctrl_symbol(s1_ctrl);
      cnt_nxt = '0;
    end
  end

  // Stage 2: register the symbol and the running disparity.
  always_ff @(posedge pix_clk or negedge resetn) begin
    if (!resetn) begin
      s2_sym <= CTRL_00;
      cnt    <= '0;
    end else begin
      s2_sym <= sym_nxt;
      cnt    <= cnt_nxt;
    end
  end

`ifdef TMDS_ENCODER_OUTREG_EN
  logic [TMDS_SYM_W-1:0] out_sym;

  // Extra retiming register in front of the serialiser.
  always_ff @(posedge pix_clk or negedge resetn) begin
    if (!resetn) begin
      out_sym <= CTRL_00;
    end else begin
      out_sym <= s2_sym;
    end
  end

  assign bus.tmds = out_sym;
`else
  assign bus.tmds = s2_sym;
`endif

endmodule
